// File: rtl/cache_bypass_rsp.sv
// Bypass DRAM response path: word extraction, response FIFO, pending tracking and flush drain.
// Optional perf counters enabled by defining CACHE_BYPASS_RSP_PERF_EN.
module cache_bypass_rsp #(
  parameter int NUM_BANKS       = 4,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int WORD_SIZE       = 4,
  parameter int DRAM_TAG_WIDTH  = 32 - $clog2(CACHE_LINE_SIZE),
  parameter int RSQ_SIZE        = 4,
  parameter int MAX_PENDING     = 8,
  localparam int WORDS          = CACHE_LINE_SIZE / WORD_SIZE,
  localparam int WSEL_BITS      = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int CORE_TAG_WIDTH = DRAM_TAG_WIDTH - WSEL_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         bypass_req_fire,
  output logic                         pending_full,
  input  logic                         dram_rsp_valid,
  input  logic [CACHE_LINE_SIZE*8-1:0] dram_rsp_data,
  input  logic [DRAM_TAG_WIDTH-1:0]    dram_rsp_tag,
  output logic                         dram_rsp_ready,
  output logic                         core_rsp_valid,
  output logic [WORD_SIZE*8-1:0]       core_rsp_data,
  output logic [CORE_TAG_WIDTH-1:0]    core_rsp_tag,
  input  logic                         core_rsp_ready,
  output logic                         busy,
  output logic                         flush_done
`ifdef CACHE_BYPASS_RSP_PERF_EN
  ,
  output logic [31:0]                  perf_rsp_count,
  output logic [31:0]                  perf_stall_cycles
`endif
);

  localparam int AW = $clog2(RSQ_SIZE);
  localparam int DW = WORD_SIZE * 8;
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_DONE
  } state_e;

  if (NUM_BANKS < 1) begin : g_bad_banks
    $error("NUM_BANKS must be at least 1");
  end

  logic [AW:0]               wptr_q, wptr_d;
  logic [AW:0]               rptr_q, rptr_d;
  logic [DW-1:0]             data_q [RSQ_SIZE];
  logic [DW-1:0]             data_d [RSQ_SIZE];
  logic [CORE_TAG_WIDTH-1:0] tag_q  [RSQ_SIZE];
  logic [CORE_TAG_WIDTH-1:0] tag_d  [RSQ_SIZE];
  logic [PW-1:0]             pend_q, pend_d;
  state_e                    state_q, state_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [DW-1:0] sel_word;

  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push  = dram_rsp_valid && !full;
  assign pop   = !empty && core_rsp_ready;

  assign dram_rsp_ready = !full;
  assign core_rsp_valid = !empty;
  assign core_rsp_data  = data_q[rptr_q[AW-1:0]];
  assign core_rsp_tag   = tag_q[rptr_q[AW-1:0]];
  assign pending_full   = (pend_q == PMAX) || (state_q == S_DRAIN);
  assign busy           = (state_q != S_IDLE);

  // Pick the addressed word out of the incoming line
  always_comb begin
    sel_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (dram_rsp_tag[WSEL_BITS-1:0] == WSEL_BITS'(w)) begin
        sel_word = dram_rsp_data[w*DW +: DW];
      end
    end
  end

  // FIFO write/read pointer and storage update
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    data_d = data_q;
    tag_d  = tag_q;
    if (push) begin
      data_d[wptr_q[AW-1:0]] = sel_word;
      tag_d[wptr_q[AW-1:0]]  = dram_rsp_tag[DRAM_TAG_WIDTH-1:WSEL_BITS];
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // Outstanding request count: saturates at both 0 and MAX_PENDING
  always_comb begin
    pend_d = pend_q;
    if (bypass_req_fire && push) begin
      pend_d = pend_q;
    end else if (bypass_req_fire && (pend_q != PMAX)) begin
      pend_d = pend_q + 1'b1;
    end else if (push && (pend_q != '0)) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Flush drain sequencing
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((pend_q == '0) && empty) state_d = S_DONE;
      end
      S_DONE: begin
        flush_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      pend_q  <= '0;
      state_q <= S_IDLE;
      for (int i = 0; i < RSQ_SIZE; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

`ifdef CACHE_BYPASS_RSP_PERF_EN
  logic [31:0] perf_rsp_count_q, perf_rsp_count_d;
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;

  assign perf_rsp_count    = perf_rsp_count_q;
  assign perf_stall_cycles = perf_stall_cycles_q;

  // Count pops and cycles where DRAM is stalled by a full FIFO
  always_comb begin
    perf_rsp_count_d    = perf_rsp_count_q;
    perf_stall_cycles_d = perf_stall_cycles_q;
    if (pop) perf_rsp_count_d = perf_rsp_count_q + 32'd1;
    if (dram_rsp_valid && full) begin
      perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
    end
  end

  // Perf counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_rsp_count_q    <= '0;
      perf_stall_cycles_q <= '0;
    end else begin
      perf_rsp_count_q    <= perf_rsp_count_d;
      perf_stall_cycles_q <= perf_stall_cycles_d;
    end
  end
`endif

endmodule

// File: tb/tb_cache_bypass_rsp.sv
// Scoreboard bench for cache_bypass_rsp with directed vectors.
// Perf counters checked when CACHE_BYPASS_RSP_PERF_EN is defined.
module tb_cache_bypass_rsp;

  localparam int CTW = 22;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         bypass_req_fire;
  logic         pending_full;
  logic         dram_rsp_valid;
  logic [511:0] dram_rsp_data;
  logic [25:0]  dram_rsp_tag;
  logic         dram_rsp_ready;
  logic         core_rsp_valid;
  logic [31:0]  core_rsp_data;
  logic [CTW-1:0] core_rsp_tag;
  logic         core_rsp_ready;
  logic         busy;
  logic         flush_done;
`ifdef CACHE_BYPASS_RSP_PERF_EN
  logic [31:0]  perf_rsp_count;
  logic [31:0]  perf_stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [CTW+31:0] q[$];

  always #5 clk = ~clk;

  cache_bypass_rsp dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .bypass_req_fire (bypass_req_fire),
    .pending_full    (pending_full),
    .dram_rsp_valid  (dram_rsp_valid),
    .dram_rsp_data   (dram_rsp_data),
    .dram_rsp_tag    (dram_rsp_tag),
    .dram_rsp_ready  (dram_rsp_ready),
    .core_rsp_valid  (core_rsp_valid),
    .core_rsp_data   (core_rsp_data),
    .core_rsp_tag    (core_rsp_tag),
    .core_rsp_ready  (core_rsp_ready),
    .busy            (busy),
`ifdef CACHE_BYPASS_RSP_PERF_EN
    .perf_rsp_count    (perf_rsp_count),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .flush_done      (flush_done)
  );

  function automatic logic [511:0] mkline(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; acc says the bench expects the push to land
  task automatic drv(input bit fire, input bit v, input logic [31:0] base,
                     input logic [CTW-1:0] ct, input logic [3:0] ws,
                     input bit acc);
    bypass_req_fire = fire;
    dram_rsp_valid  = v;
    dram_rsp_data   = mkline(base);
    dram_rsp_tag    = {ct, ws};
    if (v && acc) q.push_back({base + 32'(ws), ct});
    tick();
    bypass_req_fire = 1'b0;
    dram_rsp_valid  = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (core_rsp_valid && core_rsp_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp: got %0h/%0h expected none",
                 core_rsp_data, core_rsp_tag);
      end else begin
        logic [CTW+31:0] e;
        e = q.pop_front();
        if ({core_rsp_data, core_rsp_tag} !== e) begin
          n_bad++;
          $display("FAIL rsp: got %0h/%0h expected %0h/%0h",
                   core_rsp_data, core_rsp_tag, e[CTW+31:CTW], e[CTW-1:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; bypass_req_fire = 1'b0;
    dram_rsp_valid = 1'b0; dram_rsp_data = '0; dram_rsp_tag = '0;
    core_rsp_ready = 1'b1;
    tick(); tick();
    chk("rst_dram_ready", 32'(dram_rsp_ready), 32'd1);
    chk("rst_core_valid", 32'(core_rsp_valid), 32'd0);
    chk("rst_core_data", core_rsp_data, 32'd0);
    chk("rst_core_tag", 32'(core_rsp_tag), 32'd0);
    chk("rst_pending_full", 32'(pending_full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    reset = 1'b0;
    tick();

    // Word select: word i = 0xA0+i, wsel 7, core tag 0x15
    drv(1, 0, 0, 0, 0, 0);
    drv(0, 1, 32'hA0, 22'h15, 4'd7, 1);
    chk("lat_valid", 32'(core_rsp_valid), 32'd1);
    chk("ws7_data", core_rsp_data, 32'hA7);
    chk("ws7_tag", 32'(core_rsp_tag), 32'h15);
    tick();

    // Back-to-back pushes with other word selects
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    drv(0, 1, 32'h1111_0000, 22'h3ABCD, 4'd0, 1);
    drv(0, 1, 32'h2222_0000, 22'h00001, 4'd15, 1);
    drv(0, 1, 32'h3333_0000, 22'h2AAAA, 4'd3, 1);
    tick(); tick();
    chk("tput_empty", 32'(core_rsp_valid), 32'd0);

    // Push at pending 0 must not wrap the counter
    drv(0, 1, 32'h4444_0000, 22'h00077, 4'd9, 1);
    tick();
    for (int i = 1; i <= 8; i++) begin
      drv(1, 0, 0, 0, 0, 0);
      if (i == 7) chk("pend7_not_full", 32'(pending_full), 32'd0);
      if (i == 8) chk("pend8_full", 32'(pending_full), 32'd1);
    end
    drv(1, 0, 0, 0, 0, 0);
    chk("pend_fire_at_max", 32'(pending_full), 32'd1);
    drv(1, 1, 32'h5555_0000, 22'h00100, 4'd2, 1);
    chk("pend_fire_push", 32'(pending_full), 32'd1);
    drv(0, 1, 32'h6666_0000, 22'h00200, 4'd5, 1);
    chk("pend_one_push", 32'(pending_full), 32'd0);
    for (int i = 0; i < 7; i++) begin
      drv(0, 1, 32'h7000_0000 + 32'(i << 8), 22'(i + 1), 4'(i * 2), 1);
    end
    tick(); tick();

    // Drain with 3 pending
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_pfull", 32'(pending_full), 32'd1);
    drv(0, 1, 32'h8000_0000, 22'h00301, 4'd1, 1);
    drv(0, 1, 32'h8100_0000, 22'h00302, 4'd4, 1);
    drv(0, 1, 32'h8200_0000, 22'h00303, 4'd14, 1);
    tick();
    chk("drain_fd_early", 32'(flush_done), 32'd0);
    chk("drain_still_busy", 32'(busy), 32'd1);
    tick();
    chk("drain_fd", 32'(flush_done), 32'd1);
    tick();
    chk("drain_fd_pulse", 32'(flush_done), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);

    // Async reset mid-drain with 2 buffered entries
    core_rsp_ready = 1'b0;
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    drv(0, 1, 32'h9000_0000, 22'h00400, 4'd6, 0);
    drv(0, 1, 32'h9100_0000, 22'h00401, 4'd8, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(core_rsp_valid), 32'd0);
    chk("arst_data", core_rsp_data, 32'd0);
    chk("arst_tag", 32'(core_rsp_tag), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pfull", 32'(pending_full), 32'd0);
    chk("arst_ready", 32'(dram_rsp_ready), 32'd1);
    tick(); tick();
    reset = 1'b0;
    core_rsp_ready = 1'b1;
    tick();
    chk("arst_no_fd", 32'(flush_done), 32'd0);
    drv(1, 0, 0, 0, 0, 0);
    drv(0, 1, 32'hA100_0000, 22'h00500, 4'd11, 1);
    tick(); tick();

    // Backpressure: 4 fit, 5th offer stalls 3 cycles
    core_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) drv(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 32'hB000_0000 + 32'(i << 12), 22'(16 + i), 4'(i + 3), 1);
    end
    chk("bp_full", 32'(dram_rsp_ready), 32'd0);
    dram_rsp_valid = 1'b1;
    dram_rsp_data  = mkline(32'hBEEF_0000);
    dram_rsp_tag   = {22'h3FFFF, 4'd0};
    repeat (3) tick();
    dram_rsp_valid = 1'b0;
    chk("bp_still_full", 32'(dram_rsp_ready), 32'd0);
    chk("bp_hold_data", core_rsp_data, 32'hB000_0003);
    chk("bp_hold_tag", 32'(core_rsp_tag), 32'd16);
    core_rsp_ready = 1'b1;
    repeat (4) tick();
    chk("bp_drained", 32'(core_rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(dram_rsp_ready), 32'd1);
    drv(0, 1, 32'hC000_0000, 22'h00600, 4'd12, 1);
    tick(); tick();
`ifdef CACHE_BYPASS_RSP_PERF_EN
    chk("perf_rsp_count", perf_rsp_count, 32'd6);
    chk("perf_stall_cycles", perf_stall_cycles, 32'd3);
`endif

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
